control_sequencer: RTL
======================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 Parameters SHALL be: NREG, default 14, width of every enable vector and register index space (2..32).
REQ-002 Parameters SHALL be: AC_IDX, default 13, accumulator position; PC_IDX, default 0, program counter position; IR_IDX, default 1, instruction register position.
REQ-003 Parameters SHALL be: RP_IDX, default 3; CP_IDX, default 4; ALU_LAT, default 1, ALU latency in cycles, 1..8; MEM_TO, default 15, memory timeout in cycles.
REQ-004 The module SHALL have one clock and a synchronous, active-high reset, with ports listed below.
REQ-005 Port clk SHALL be an input, 1 bit, clock; all state changes SHALL occur on its falling edge.
REQ-006 Port rst SHALL be an input, 1 bit, synchronous active-high reset.
REQ-007 Port ins SHALL be an input, 8 bits, instruction from IR: class is ins[7:5], operand is ins[4:0].
REQ-008 Port z1 SHALL be an input, 1 bit, zero flag 1; port z2 SHALL be an input, 1 bit, zero flag 2; port mem_ack SHALL be an input, 1 bit, memory access complete.
REQ-009 Ports alu_op (3 bits), bus_sel (4 bits) and pctrl (2 bits) SHALL be outputs: ALU operation, bus source and pointer select.
REQ-010 Ports wrt_en, inc_en and rst_en SHALL be outputs, NREG bits each: per-register write, increment and reset strobes.
REQ-011 Port mem_ctrl SHALL be an output, 2 bits: IDLE, READ or WRITE.
REQ-012 Ports halted, illegal and err SHALL be outputs, 1 bit each: stopped, 1-cycle bad-opcode pulse and timeout flag.

Function
REQ-013 Outputs SHALL be registered and SHALL be a pure function of the state just entered and the latched opcode (Moore); outputs not listed for a state SHALL be ALU_NONE, BS_AC, P_GSP, MEM_IDLE and all-zero vectors.
REQ-014 The FSM states SHALL be FETCH, FETCH_WB, DECODE, MEM, MEM_WB, ALU_WAIT, ALU_WB, EXEC, HALT and ERR.
REQ-015 In FETCH the block SHALL drive mem_ctrl=READ with pctrl=P_GSP, and SHALL hold in FETCH until mem_ack=1.
REQ-016 FETCH_WB SHALL drive bus_sel=BS_MEMOUT, wrt_en[IR_IDX] and inc_en[PC_IDX], then go to DECODE.
REQ-017 DECODE SHALL latch ins and dispatch by class; each class below SHALL return to FETCH unless stated otherwise.
REQ-018 Class 000, ctl, SHALL be decoded by operand: 0 = NOP; 1 = HALT, entering HALT; 2 = RSTALL, one EXEC cycle with rst_en = all ones except PC_IDX and IR_IDX.
REQ-019 Class 001, rst rd, SHALL drive rst_en[rd] in EXEC.
REQ-020 Class 010, inc rd, SHALL drive inc_en[rd] in EXEC.
REQ-021 Class 011, mov rd, SHALL drive wrt_en[rd] with bus_sel=BS_AC in EXEC.
REQ-022 Class 100, ld rd, SHALL use MEM with READ, pctrl = P_RP if rd=RP_IDX, P_CP if rd=CP_IDX, otherwise P_GSP, holding until mem_ack; it SHALL then use MEM_WB with BS_MEMOUT and wrt_en[rd].
REQ-023 Class 101, st, SHALL use MEM with WRITE, P_STP and BS_AC, holding until mem_ack.
REQ-024 Class 110, alu, SHALL drive alu_op=ins[4:2] and bus_sel=ins[1:0], zero-extended, in ALU_WAIT for exactly ALU_LAT cycles, then ALU_WB with wrt_en[AC_IDX].
REQ-025 Class 111, jmp, SHALL select its condition from ins[1:0]: 00 always, 01 z1, 10 z2, 11 illegal, with the condition sampled in DECODE.
REQ-026 A taken jump SHALL drive wrt_en[PC_IDX] with BS_AC in EXEC; a not-taken jump SHALL drive inc_en[PC_IDX].
REQ-027 An operand rd >= NREG, an unused ctl code or jmp cond 11 SHALL pulse illegal for 1 cycle, execute nothing, and return to FETCH.
REQ-028 HALT SHALL drive halted=1 and SHALL be left only by reset.
REQ-029 A mem_ack arriving outside FETCH or MEM SHALL be ignored.
REQ-030 At most one bit of wrt_en SHALL be set in any cycle, and the same holds for inc_en; rst_en is multi-bit only in RSTALL.
REQ-031 Latency SHALL be: NOP, rst, inc, mov and jmp = 4 cycles with immediate ack; ld = 5 cycles; alu = 4+ALU_LAT cycles.

Reset
REQ-032 rst=1 at a falling edge SHALL force FETCH, clear the latched opcode, the wait counter and err, and drive outputs to their idle values with halted=0 and illegal=0.
REQ-033 Reset SHALL take priority in every state, including mid-MEM and mid-ALU_WAIT, with no write strobe emitted afterwards.

Configuration
REQ-034 With CU_MEM_TIMEOUT_EN defined, MEM_TO consecutive cycles without mem_ack in FETCH or MEM SHALL enter ERR; ERR SHALL drive err=1 with idle outputs and be sticky until reset.
REQ-035 Without CU_MEM_TIMEOUT_EN, FETCH and MEM SHALL wait indefinitely and err SHALL be tied to 0.

Structure
REQ-036 Package cu_pkg SHALL hold the class codes, ALU_*, BS_*, P_* and MEM_* encodings, and the state enum.
REQ-037 Sub-module cu_wait_counter SHALL be a loadable down-counter with a zero flag, shared by the ALU latency and timeout functions.

Verification (NREG=14, ALU_LAT=2, MEM_TO=15)
REQ-038 ins=0x4D with ack every cycle SHALL produce IR write, PC increment, then inc_en=0x2000 for 1 cycle, then FETCH.
REQ-039 ins=0x83 with ack delayed 3 cycles SHALL hold pctrl=P_RP and READ for 4 cycles, then wrt_en=0x0008 with BS_MEMOUT.
REQ-040 ins=0xC5 SHALL produce alu_op=1 and bus_sel=1 for 2 cycles, then wrt_en=0x2000.
REQ-041 ins=0xE1 with z1=1 SHALL produce wrt_en=0x0001; with z1=0 it SHALL produce inc_en=0x0001; ins=0xE3 SHALL pulse illegal.
REQ-042 ins=0x01 SHALL set halted=1 indefinitely; rst=1 asserted during a held MEM read SHALL return to FETCH with no wrt_en.
REQ-043 With CU_MEM_TIMEOUT_EN, ack withheld for 15 cycles SHALL set err=1 and enter ERR.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared encodings for the control sequencer: instruction classes, ALU/bus/pointer/memory
// selects and the FSM state enum.
package cu_pkg;

  typedef enum logic [2:0] {
    C_CTL = 3'b000,
    C_RST = 3'b001,
    C_INC = 3'b010,
    C_MOV = 3'b011,
    C_LD  = 3'b100,
    C_ST  = 3'b101,
    C_ALU = 3'b110,
    C_JMP = 3'b111
  } cls_e;

  localparam logic [4:0] CTL_NOP    = 5'd0;
  localparam logic [4:0] CTL_HALT   = 5'd1;
  localparam logic [4:0] CTL_RSTALL = 5'd2;

  localparam logic [2:0] ALU_NONE   = 3'd0;

  localparam logic [3:0] BS_AC      = 4'h0;
  localparam logic [3:0] BS_MEMOUT  = 4'h8;

  localparam logic [1:0] P_GSP      = 2'd0;
  localparam logic [1:0] P_RP       = 2'd1;
  localparam logic [1:0] P_CP       = 2'd2;
  localparam logic [1:0] P_STP      = 2'd3;

  localparam logic [1:0] MEM_IDLE   = 2'd0;
  localparam logic [1:0] MEM_READ   = 2'd1;
  localparam logic [1:0] MEM_WRITE  = 2'd2;

  typedef enum logic [3:0] {
    FETCH, FETCH_WB, DECODE, MEM, MEM_WB, ALU_WAIT, ALU_WB, EXEC, HALT, ERR
  } state_e;

endpackage

// File: rtl/control_sequencer_if.sv
// Instruction/flag inputs and control-strobe outputs of the sequencer; master = sequencer side.
interface control_sequencer_if #(parameter int NREG = 14);
  logic [7:0]      ins;
  logic            z1, z2, mem_ack;
  logic [2:0]      alu_op;
  logic [3:0]      bus_sel;
  logic [1:0]      pctrl;
  logic [NREG-1:0] wrt_en, inc_en, rst_en;
  logic [1:0]      mem_ctrl;
  logic            halted, illegal, err;

  modport master (
    input  ins, z1, z2, mem_ack,
    output alu_op, bus_sel, pctrl, wrt_en, inc_en, rst_en, mem_ctrl, halted, illegal, err
  );

  modport slave (
    output ins, z1, z2, mem_ack,
    input  alu_op, bus_sel, pctrl, wrt_en, inc_en, rst_en, mem_ctrl, halted, illegal, err
  );
endinterface

// File: rtl/cu_wait_counter.sv
// Loadable down-counter with zero flag; saturates at zero. Times both ALU latency and memory waits.
module cu_wait_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          i_load,
  input  logic [CW-1:0] i_val,
  output logic          o_zero
);
  logic [CW-1:0] r_cnt;

  always_ff @(negedge clk) begin
    if (i_load)
      r_cnt <= i_val;
    else if (r_cnt != '0)
      r_cnt <= r_cnt - 1'b1;
  end

  assign o_zero = (r_cnt == '0);
endmodule

// File: rtl/control_sequencer.sv
// Moore control sequencer: fetch/decode/execute FSM with registered strobes, falling-edge state.
// Optional memory timeout into a sticky ERR state when CU_MEM_TIMEOUT_EN is defined.
module control_sequencer
  import cu_pkg::*;
#(
  parameter int NREG    = 14,
  parameter int AC_IDX  = 13,
  parameter int PC_IDX  = 0,
  parameter int IR_IDX  = 1,
  parameter int RP_IDX  = 3,
  parameter int CP_IDX  = 4,
  parameter int ALU_LAT = 1,
  parameter int MEM_TO  = 15
) (
  input logic                 clk,
  input logic                 rst,
  control_sequencer_if.master bus
);
  localparam int CW = $clog2(((MEM_TO > ALU_LAT) ? MEM_TO : ALU_LAT) + 1);

  state_e          r_state, w_nxt;
  logic [7:0]      r_ins, w_ins;
  logic            r_taken, w_taken, w_bad, w_timeout, w_cnt_zero, w_cnt_load;
  logic [CW-1:0]   w_cnt_val;
  cls_e            w_cls;
  logic [4:0]      w_rd;
  logic [NREG-1:0] w_rd_oh;

  logic [2:0]      r_alu, w_alu;
  logic [3:0]      r_bs, w_bs;
  logic [1:0]      r_pc, w_pc, r_mem, w_mem;
  logic [NREG-1:0] r_wrt, w_wrt, r_inc, w_inc, r_rse, w_rse;
  logic            r_halt, w_halt, r_ill, w_ill;

  // The opcode is captured while leaving DECODE; outputs of the state being entered use it directly.
  assign w_ins   = (r_state == DECODE) ? bus.ins : r_ins;
  assign w_cls   = cls_e'(w_ins[7:5]);
  assign w_rd    = w_ins[4:0];
  assign w_rd_oh = {{(NREG-1){1'b0}}, 1'b1} << w_rd;

  always_comb begin
    w_bad   = 1'b0;
    w_taken = r_taken;
    case (w_cls)
      C_CTL:                     w_bad = (w_rd > CTL_RSTALL);
      C_RST, C_INC, C_MOV, C_LD: w_bad = ({27'd0, w_rd} >= 32'(NREG));
      C_JMP:                     w_bad = (w_ins[1:0] == 2'b11);
      default:                   w_bad = 1'b0;
    endcase
    if (r_state == DECODE) begin
      case (w_ins[1:0])
        2'b00:   w_taken = 1'b1;
        2'b01:   w_taken = bus.z1;
        2'b10:   w_taken = bus.z2;
        default: w_taken = 1'b0;
      endcase
    end
  end

  always_comb begin
    w_nxt = r_state;
    case (r_state)
      FETCH:    if (bus.mem_ack) w_nxt = FETCH_WB; else if (w_timeout) w_nxt = ERR;
      FETCH_WB: w_nxt = DECODE;
      DECODE: begin
        if (w_bad)                                 w_nxt = EXEC;
        else if (w_cls == C_CTL && w_rd == CTL_HALT) w_nxt = HALT;
        else if (w_cls == C_LD || w_cls == C_ST)   w_nxt = MEM;
        else if (w_cls == C_ALU)                   w_nxt = ALU_WAIT;
        else                                       w_nxt = EXEC;
      end
      MEM: begin
        if (bus.mem_ack)    w_nxt = (w_cls == C_LD) ? MEM_WB : FETCH;
        else if (w_timeout) w_nxt = ERR;
      end
      ALU_WAIT:                 if (w_cnt_zero) w_nxt = ALU_WB;
      MEM_WB, ALU_WB, EXEC:     w_nxt = FETCH;
      HALT, ERR:                w_nxt = r_state;
      default:                  w_nxt = FETCH;
    endcase
  end

  always_comb begin
    w_alu  = ALU_NONE;
    w_bs   = BS_AC;
    w_pc   = P_GSP;
    w_mem  = MEM_IDLE;
    w_wrt  = '0;
    w_inc  = '0;
    w_rse  = '0;
    w_halt = 1'b0;
    w_ill  = 1'b0;
    case (w_nxt)
      FETCH:    w_mem = MEM_READ;
      FETCH_WB: begin
        w_bs          = BS_MEMOUT;
        w_wrt[IR_IDX] = 1'b1;
        w_inc[PC_IDX] = 1'b1;
      end
      MEM: begin
        if (w_cls == C_LD) begin
          w_mem = MEM_READ;
          w_pc  = (w_rd == 5'(RP_IDX)) ? P_RP : (w_rd == 5'(CP_IDX)) ? P_CP : P_GSP;
        end else begin
          w_mem = MEM_WRITE;
          w_pc  = P_STP;
        end
      end
      MEM_WB: begin
        w_bs  = BS_MEMOUT;
        w_wrt = w_rd_oh;
      end
      ALU_WAIT: begin
        w_alu = w_ins[4:2];
        w_bs  = {2'b00, w_ins[1:0]};
      end
      ALU_WB:   w_wrt[AC_IDX] = 1'b1;
      EXEC: begin
        if (w_bad) w_ill = 1'b1;
        else begin
          case (w_cls)
            C_CTL: if (w_rd == CTL_RSTALL) begin
              w_rse         = '1;
              w_rse[PC_IDX] = 1'b0;
              w_rse[IR_IDX] = 1'b0;
            end
            C_RST: w_rse = w_rd_oh;
            C_INC: w_inc = w_rd_oh;
            C_MOV: w_wrt = w_rd_oh;
            C_JMP: if (w_taken) w_wrt[PC_IDX] = 1'b1; else w_inc[PC_IDX] = 1'b1;
            default: ;
          endcase
        end
      end
      HALT:     w_halt = 1'b1;
      default:  ;
    endcase
  end

  // Reset reloads the counter so the first fetch gets a full timeout window.
  assign w_cnt_load = rst || ((w_nxt != r_state) &&
                              (w_nxt == FETCH || w_nxt == MEM || w_nxt == ALU_WAIT));
  assign w_cnt_val  = (!rst && w_nxt == ALU_WAIT) ? CW'(ALU_LAT - 1) : CW'(MEM_TO - 1);

  cu_wait_counter #(.CW(CW)) u_wait (
    .clk    (clk),
    .i_load (w_cnt_load),
    .i_val  (w_cnt_val),
    .o_zero (w_cnt_zero)
  );

  always_ff @(negedge clk) begin
    if (rst) begin
      r_state <= FETCH;
      r_ins   <= '0;
      r_taken <= 1'b0;
      r_alu   <= ALU_NONE;
      r_bs    <= BS_AC;
      r_pc    <= P_GSP;
      r_mem   <= MEM_IDLE;
      r_wrt   <= '0;
      r_inc   <= '0;
      r_rse   <= '0;
      r_halt  <= 1'b0;
      r_ill   <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_ins   <= w_ins;
      r_taken <= w_taken;
      r_alu   <= w_alu;
      r_bs    <= w_bs;
      r_pc    <= w_pc;
      r_mem   <= w_mem;
      r_wrt   <= w_wrt;
      r_inc   <= w_inc;
      r_rse   <= w_rse;
      r_halt  <= w_halt;
      r_ill   <= w_ill;
    end
  end

`ifdef CU_MEM_TIMEOUT_EN
  logic r_err;
  always_ff @(negedge clk) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= (w_nxt == ERR);
  end
  assign bus.err   = r_err;
  assign w_timeout = w_cnt_zero;
`else
  assign bus.err   = 1'b0;
  assign w_timeout = 1'b0;
`endif

  assign bus.alu_op   = r_alu;
  assign bus.bus_sel  = r_bs;
  assign bus.pctrl    = r_pc;
  assign bus.mem_ctrl = r_mem;
  assign bus.wrt_en   = r_wrt;
  assign bus.inc_en   = r_inc;
  assign bus.rst_en   = r_rse;
  assign bus.halted   = r_halt;
  assign bus.illegal  = r_ill;
endmodule
